// File: rtl/pipelined_heap_queue.sv
// Binary-heap priority queue: root in a register, deeper levels in a dual-port
// synchronous-read RAM, with sift-up on enqueue and sift-down on dequeue/replace.
module pipelined_heap_queue #(
    parameter int QUEUE_SIZE = 7,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_HEAP   = 1
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              i_wrt,
    input  logic                              i_read,
    input  logic [DATA_WIDTH-1:0]             i_data,
    output logic                              o_ready,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_count,
    output logic                              o_full,
    output logic                              o_empty,
    output logic                              o_err
);

    localparam int TREE_DEPTH = $clog2(QUEUE_SIZE + 1);
    // One extra bit so child indices of the deepest parents never wrap.
    localparam int IW         = TREE_DEPTH + 1;
    localparam int RAM_DEPTH  = 2 ** TREE_DEPTH;

    typedef logic [TREE_DEPTH-1:0] cnt_t;
    typedef logic [IW-1:0]         idx_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam cnt_t CNT_FULL = cnt_t'(QUEUE_SIZE);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam idx_t IDX_ROOT = idx_t'(1);
    localparam idx_t IDX_TWO  = idx_t'(2);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RD, S_WAIT, S_CMP} state_t;
    typedef enum logic [1:0] {OP_UP, OP_DOWN, OP_FETCH} op_t;

    state_t          state;
    op_t             op;
    cnt_t            count_q;
    data_t           root_q;
    data_t           cur_q;
    idx_t            idx_q;
    logic [TREE_DEPTH-1:0] raddr_a, raddr_b;
    logic            ready_q;
    logic            err_q;

    data_t           mem [0:RAM_DEPTH-1];
    data_t           rd_a, rd_b;

    logic            wa_en, wb_en;
    logic [TREE_DEPTH-1:0] wa_addr, wb_addr;
    data_t           wa_data, wb_data;

    idx_t            count_x;
    idx_t            parent_i, left_i, right_i, best_i, best_left_i;
    data_t           parent_v, best_v;
    logic            up_swap, down_swap, pick_right, more_work;
    logic            go, is_enq, is_deq, illegal;

    function automatic logic higher(input data_t a, input data_t b);
        if (MAX_HEAP != 0) return a > b;
        else               return a < b;
    endfunction

    assign count_x = {1'b0, count_q};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        parent_i    = {1'b0, idx_q[IW-1:1]};
        left_i      = {idx_q[IW-2:0], 1'b0};
        right_i     = {idx_q[IW-2:0], 1'b1};
        parent_v    = (parent_i == IDX_ROOT) ? root_q : rd_a;
        up_swap     = higher(cur_q, parent_v);
        pick_right  = (right_i <= count_x) && higher(rd_b, rd_a);
        best_i      = pick_right ? right_i : left_i;
        best_v      = pick_right ? rd_b : rd_a;
        best_left_i = {best_i[IW-2:0], 1'b0};
        down_swap   = higher(best_v, cur_q);
        more_work   = (op == OP_UP) ? (idx_q != IDX_ROOT) : (left_i <= count_x);

        go      = (state == S_IDLE) && (i_wrt || i_read);
        is_enq  = i_wrt && (!i_read || count_q == '0);
        is_deq  = i_read && !i_wrt;
        illegal = (is_enq && count_q == CNT_FULL) || (is_deq && count_q == '0);

        wa_en   = 1'b0;
        wa_addr = '0;
        wa_data = '0;
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        if (go && !illegal && is_enq && count_q != '0) begin
            wa_en   = 1'b1;
            wa_addr = count_q + CNT_ONE;
            wa_data = i_data;
        end else if (state == S_CMP && op == OP_UP && up_swap) begin
            wa_en   = 1'b1;
            wa_addr = idx_q[TREE_DEPTH-1:0];
            wa_data = parent_v;
            wb_en   = (parent_i != IDX_ROOT);
            wb_addr = parent_i[TREE_DEPTH-1:0];
            wb_data = cur_q;
        end else if (state == S_CMP && op == OP_DOWN && down_swap) begin
            wa_en   = 1'b1;
            wa_addr = best_i[TREE_DEPTH-1:0];
            wa_data = cur_q;
            wb_en   = (idx_q != IDX_ROOT);
            wb_addr = idx_q[TREE_DEPTH-1:0];
            wb_data = best_v;
        end
    end

    // NOTE: RAM contents are deliberately left out of reset; slots beyond the count are never trusted.
    always_ff @(posedge CLK) begin
        if (wa_en) mem[wa_addr] <= wa_data;
        if (wb_en) mem[wb_addr] <= wb_data;
        rd_a <= mem[raddr_a];
        rd_b <= mem[raddr_b];
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            op      <= OP_UP;
            count_q <= '0;
            root_q  <= '0;
            cur_q   <= '0;
            idx_q   <= '0;
            raddr_a <= '0;
            raddr_b <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go && illegal) begin
                        err_q <= 1'b1;
                    end else if (go) begin
                        ready_q <= 1'b0;
                        state   <= S_RD;
                        if (is_enq) begin
                            count_q <= count_q + CNT_ONE;
                            op      <= OP_UP;
                            cur_q   <= i_data;
                            if (count_q == '0) begin
                                root_q <= i_data;
                                idx_q  <= IDX_ROOT;
                            end else begin
                                idx_q  <= count_x + IDX_ROOT;
                            end
                        end else if (is_deq) begin
                            count_q <= count_q - CNT_ONE;
                            if (count_q == CNT_ONE) begin
                                root_q <= '0;
                                op     <= OP_DOWN;
                                idx_q  <= IDX_ROOT;
                            end else begin
                                op     <= OP_FETCH;
                                idx_q  <= count_x;
                                state  <= S_FETCH;
                            end
                        end else begin
                            root_q <= i_data;
                            cur_q  <= i_data;
                            op     <= OP_DOWN;
                            idx_q  <= IDX_ROOT;
                        end
                    end
                end
                S_FETCH: begin
                    raddr_a <= idx_q[TREE_DEPTH-1:0];
                    state   <= S_WAIT;
                end
                S_RD: begin
                    if (!more_work) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        raddr_a <= (op == OP_UP) ? parent_i[TREE_DEPTH-1:0] : left_i[TREE_DEPTH-1:0];
                        raddr_b <= right_i[TREE_DEPTH-1:0];
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: state <= S_CMP;
                S_CMP: begin
                    // Each compare either schedules the next level's reads or finishes.
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    case (op)
                        OP_FETCH: begin
                            root_q <= rd_a;
                            cur_q  <= rd_a;
                            idx_q  <= IDX_ROOT;
                            op     <= OP_DOWN;
                            if (IDX_TWO <= count_x) begin
                                state   <= S_RD;
                                ready_q <= 1'b0;
                            end
                        end
                        OP_UP: begin
                            if (up_swap) begin
                                idx_q <= parent_i;
                                if (parent_i == IDX_ROOT) begin
                                    root_q <= cur_q;
                                end else begin
                                    state   <= S_RD;
                                    ready_q <= 1'b0;
                                end
                            end
                        end
                        default: begin
                            if (down_swap) begin
                                idx_q <= best_i;
                                if (idx_q == IDX_ROOT) root_q <= best_v;
                                if (best_left_i <= count_x) begin
                                    state   <= S_RD;
                                    ready_q <= 1'b0;
                                end
                            end
                        end
                    endcase
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_data  = root_q;
    assign o_count = count_q;
    assign o_full  = (count_q == CNT_FULL);
    assign o_empty = (count_q == '0);
    assign o_err   = err_q;

endmodule

// File: doc/pipelined_heap_queue.md
Name: pipelined_heap_queue

Overview:
- Parametrised binary-heap priority queue. Successor to the fixed max-only BRAM tree queue.
- Adds a selectable min/max ordering, a true enqueue path with sift-up, a ready/busy handshake, an occupancy count, and error flagging.
- Root is held in a register and always presented on o_data. Levels 1 and below are held in synchronous-read RAM (1-cycle read latency).
- Sits between a scheduler/sorter front-end and downstream consumers that pop the top-priority item.

Parameters:
QUEUE_SIZE, 7, maximum number of stored entries (any value >= 1); TREE_DEPTH = $clog2(QUEUE_SIZE+1)
DATA_WIDTH, 16, width of one entry (unsigned compare)
MAX_HEAP, 1, 1 = root is the largest entry; 0 = root is the smallest entry

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
i_wrt  input  1  enqueue request (with i_read = replace)
i_read  input  1  dequeue request (with i_wrt = replace)
i_data  input  DATA_WIDTH  entry for enqueue/replace
o_ready  output  1  high when a command will be accepted this cycle
o_data  output  DATA_WIDTH  current root (top priority); 0 when empty
o_count  output  $clog2(QUEUE_SIZE+1)  number of stored entries
o_full  output  1  o_count == QUEUE_SIZE
o_empty  output  1  o_count == 0
o_err  output  1  one-cycle pulse on an illegal command

Behaviour:
- One clock (CLK); reset RST is synchronous, active-high.
- Reset values: o_ready=1, o_data=0, o_count=0, o_full=0, o_empty=1, o_err=0, FSM=IDLE. RAM contents are don't-care.
- Reset asserted mid-operation aborts any sift. Next cycle is IDLE with count 0.
- Acceptance: a command is accepted on an edge where o_ready=1 and (i_wrt|i_read)=1. Requests while o_ready=0 are ignored; they are not queued and do not raise o_err.
- Decode:
  - i_wrt&!i_read = ENQ.
  - !i_wrt&i_read = DEQ.
  - both = REPL.
  - REPL when empty behaves exactly as ENQ.
- Illegal commands: ENQ when full, or DEQ when empty. Not accepted; state unchanged, o_ready stays 1, o_err=1 the following cycle.
- Index scheme: heap indices are 1-based (root=1, children 2i and 2i+1). The last entry is at index o_count.
- o_count updates on the cycle after acceptance: ENQ +1, DEQ -1, REPL unchanged.
- ENQ:
  - Write i_data at index count+1.
  - If the queue was empty, write to the root register directly; done.
  - Otherwise sift-up: compare the node with its parent. Swap if the node has strictly higher priority (> for MAX_HEAP=1, < for 0). Stop on tie, at the root, or on no swap.
- DEQ:
  - If count==1: root <= 0; done.
  - Otherwise read the entry at index count, move it to the root, then sift-down.
- REPL: root <= i_data, then sift-down.
- Sift-down step: compare the parent with both children.
  - Children beyond count are treated as absent, never compared.
  - Pick the higher-priority child; the left child wins ties.
  - Swap only if that child is strictly higher priority than the parent; otherwise stop.
  - Also stop at the last valid level.
- FSM states:
  - IDLE: o_ready=1.
  - FETCH: issue RAM read of the last entry (DEQ only).
  - RD: issue reads of the parent and child/children.
  - WAIT: RAM data returns.
  - CMP: compare, write swapped values (RAM write and/or root register), then go to RD or IDLE.
- Each sift level costs exactly 3 cycles (RD, WAIT, CMP).
- o_ready drops the cycle after acceptance and stays low until the FSM is back in IDLE.
- Worst-case busy time is 3 + 3*(TREE_DEPTH-1) cycles.
- Trivial busy time is exactly 1 cycle: ENQ into an empty queue, or DEQ with count==1.
- o_data:
  - Is the registered root.
  - Changes during a sift only when the root register is written.
  - Is final when o_ready returns to 1.
- Depth: RAM depth covers indices 2..2^TREE_DEPTH-1; unused slots are never read as valid.

Test Plan:
- Reset, then ENQ 5, 9, 3, 12 (MAX_HEAP=1, waiting for o_ready each time) -> o_data 5,9,9,12; o_count 4; o_empty=0.
- From that state, DEQ x4 -> o_data after each: 9,5,3,0; o_count 3,2,1,0; o_empty=1 at the end.
- MAX_HEAP=0: ENQ 40,10,30,20,50,60,70 -> o_full=1, o_data=10. An 8th ENQ -> o_err pulse, count stays 7. Then DEQ x7 yields 10,20,30,40,50,60,70.
- REPL on empty with i_data=7 -> o_count=1, o_data=7. REPL 2 on {7,4,6} with MAX_HEAP=1 -> o_data=6, count unchanged at 3.
- DEQ on empty -> o_err=1 for one cycle, o_ready stays 1. A request held while o_ready=0 is ignored, with no count change.
- Assert RST during a 3-level sift-down -> next cycle o_ready=1, o_count=0, o_data=0, o_empty=1.
